fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one UART TX fifo between two byte producers.

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one UART TX fifo between two byte producers.
// Grants are held for bursts of up to MAX_BURST accepted bytes; writes stall on fifo_full.
module fifo_wr_arbiter #(
  parameter int B         = 8,
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic [B-1:0] data0,
  input  logic         req1,
  input  logic [B-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         ack0,
  output logic         ack1,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_w_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state_r, next_state_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          last_r, last_nxt_s;

  // State, burst counter and round-robin pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      count_r <= '0;
      last_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      count_r <= count_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign gnt0 = (state_r == OWN0);
  assign gnt1 = (state_r == OWN1);

  // Next-state, burst accounting and fifo write-side decode
  always_comb begin
    next_state_s = state_r;
    count_nxt_s  = count_r;
    last_nxt_s   = last_r;
    ack0         = 1'b0;
    ack1         = 1'b0;
    fifo_wr      = 1'b0;
    fifo_w_data  = '0;
    case (state_r)
      IDLE: begin
        count_nxt_s = '0;
        if (req0 && req1) begin
          next_state_s = last_r ? OWN0 : OWN1;
        end else if (req0) begin
          next_state_s = OWN0;
        end else if (req1) begin
          next_state_s = OWN1;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN0: begin
        ack0        = req0 & ~fifo_full;
        fifo_wr     = ack0;
        fifo_w_data = data0;
        // Release on the last beat of a burst or when the producer has nothing left
        if ((ack0 && (count_r == LAST_BEAT)) || !req0) begin
          last_nxt_s   = 1'b0;
          count_nxt_s  = '0;
          next_state_s = req1 ? OWN1 : IDLE;
        end else if (ack0) begin
          count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          count_nxt_s = count_r;
        end
      end
      OWN1: begin
        ack1        = req1 & ~fifo_full;
        fifo_wr     = ack1;
        fifo_w_data = data1;
        if ((ack1 && (count_r == LAST_BEAT)) || !req1) begin
          last_nxt_s   = 1'b1;
          count_nxt_s  = '0;
          next_state_s = req0 ? OWN0 : IDLE;
        end else if (ack1) begin
          count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        count_nxt_s  = '0;
        last_nxt_s   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural ownership model.
module tb_fifo_wr_arbiter;
  localparam int B  = 8;
  localparam int MB = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, fifo_full = 1'b0;
  logic [B-1:0] data0 = '0, data1 = '0;
  logic         gnt0, gnt1, ack0, ack1, fifo_wr;
  logic [B-1:0] fifo_w_data;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.B(B), .MAX_BURST(MB), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [7:0] q0[$], q1[$], wlog[$];
  int         wcyc[$];
  int         p0 = 0, p1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the fifo (-1 none), bytes taken in this burst, who was served last
  typedef struct packed { int owner; int taken; int last; } mstate_t;
  mstate_t m = '{owner: -1, taken: 0, last: 1};

  function automatic mstate_t next_model(mstate_t s, logic r0, logic r1, logic full);
    mstate_t n;
    logic    r[2];
    int      o;
    bit      done;
    n = s; r[0] = r0; r[1] = r1; done = 0;
    if (s.owner < 0) begin
      n.taken = 0;
      if (r0 && r1) n.owner = 1 - s.last;
      else if (r0)  n.owner = 0;
      else if (r1)  n.owner = 1;
    end else begin
      o = s.owner;
      if (r[o] && !full) begin
        n.taken = s.taken + 1;
        done = (n.taken == MB);
      end else if (!r[o]) begin
        done = 1;
      end
      if (done) begin
        n.last  = o;
        n.taken = 0;
        n.owner = r[1-o] ? 1 - o : -1;
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] exp_out(mstate_t s, logic r0, logic r1, logic full,
                                          logic [7:0] d0, logic [7:0] d1);
    logic g0, g1, a0, a1;
    logic [7:0] d;
    g0 = (s.owner == 0);
    g1 = (s.owner == 1);
    a0 = g0 & r0 & ~full;
    a1 = g1 & r1 & ~full;
    d  = g0 ? d0 : (g1 ? d1 : 8'h00);
    return {g0, g1, a0, a1, a0 | a1, d};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{owner: -1, taken: 0, last: 1};
    else          m <= next_model(m, req0, req1, fifo_full);
  end

  // Per-cycle comparison against the model, plus a log of what the fifo receives
  always @(negedge clk) begin
    chk("outputs", {19'd0, gnt0, gnt1, ack0, ack1, fifo_wr, fifo_w_data},
        {19'd0, exp_out(m, req0, req1, fifo_full, data0, data1)});
    if (fifo_wr === 1'b1) begin
      wlog.push_back(fifo_w_data);
      wcyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic prod_update(input logic a0, input logic a1);
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    if (!(req0 && !a0)) begin
      req0  = (q0.size() > 0) && ($urandom_range(99, 0) < p0);
      data0 = (q0.size() > 0) ? q0[0] : 8'h00;
    end
    if (!(req1 && !a1)) begin
      req1  = (q1.size() > 0) && ($urandom_range(99, 0) < p1);
      data1 = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  endtask

  task automatic tick();
    logic a0, a1;
    @(negedge clk);
    a0 = ack0; a1 = ack1;
    @(posedge clk);
    #1;
    prod_update(a0, a1);
  endtask

  task automatic setup(input int np0, input int np1);
    reset_n = 1'b0; fifo_full = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    q0.delete(); q1.delete();
    p0 = np0; p1 = np1;
  endtask

  task automatic release_reset();
    tick(); tick();
    reset_n = 1'b1;
    wlog.delete(); wcyc.delete();
  endtask

  initial begin
    int guard;
    // Reset with both requesting, then requester 0 wins first
    setup(100, 100);
    for (int i = 0; i < 8; i++) begin q0.push_back(8'hA0 + 8'(i)); q1.push_back(8'hB0 + 8'(i)); end
    tick(); tick();
    #1;
    chk("rst_outputs", {gnt0, gnt1, ack0, ack1, fifo_wr, fifo_w_data}, 13'd0);
    reset_n = 1'b1;
    tick(); #1;
    chk("rst_first_gnt", {gnt0, gnt1}, 2'b10);
    chk("rst_first_wr", {ack0, ack1, fifo_wr, fifo_w_data}, {3'b101, 8'hA0});

    // Single requester: bursts of 4 with an idle cycle between
    setup(0, 100);
    for (int i = 0; i < 10; i++) q1.push_back(8'h10 + 8'(i));
    release_reset();
    guard = 0;
    while (wlog.size() < 10 && guard < 40) begin tick(); guard++; end
    chk("t2_count", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("t2_byte", wlog[i], 8'h10 + 8'(i));
    for (int i = 1; i < 10 && i < wcyc.size(); i++)
      chk("t2_gap", wcyc[i] - wcyc[i-1], (i % 4 == 0) ? 2 : 1);

    // Backpressure after 2 bytes: stall 5 cycles, then exactly 2 more
    setup(100, 0);
    for (int i = 0; i < 12; i++) q0.push_back(8'h40 + 8'(i));
    release_reset();
    guard = 0;
    while (wlog.size() < 2 && guard < 20) begin tick(); guard++; end
    chk("t4_setup", wlog.size(), 2);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall", {gnt0, ack0, fifo_wr}, 3'b100);
      tick();
    end
    fifo_full = 1'b0;
    tick(); tick(); #1;
    chk("t4_release_gnt", gnt0, 1'b0);
    chk("t4_total", wlog.size(), 4);

    // Early release: requester 0 has a single byte, requester 1 waiting
    setup(100, 100);
    q0.push_back(8'h5A);
    for (int i = 0; i < 4; i++) q1.push_back(8'hC0 + 8'(i));
    release_reset();
    tick(); #1;
    chk("t5_first", {gnt0, ack0, fifo_w_data}, {2'b11, 8'h5A});
    tick(); #1;
    chk("t5_drop", {gnt0, gnt1, fifo_wr}, 3'b100);
    tick(); #1;
    chk("t5_handoff", {gnt0, gnt1, fifo_wr, fifo_w_data}, {3'b011, 8'hC0});
    chk("t5_writes", wlog.size(), 1);

    // Async reset mid-burst of requester 1
    setup(0, 100);
    for (int i = 0; i < 6; i++) q1.push_back(8'hD0 + 8'(i));
    release_reset();
    tick(); #1;
    chk("t6_own1", {gnt1, fifo_wr}, 2'b11);
    #1; reset_n = 1'b0; #1;
    chk("t6_async", {gnt1, fifo_wr}, 2'b00);
    q0.push_back(8'hE0); p0 = 100;
    tick();
    reset_n = 1'b1;
    tick(); #1;
    chk("t6_after", {gnt0, gnt1}, 2'b10);
    chk("t6_no_write", wlog.size(), 0);

    // Randomized traffic with backpressure and occasional async resets
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin p0 = $urandom_range(100, 20); p1 = $urandom_range(100, 20); end
      while (q0.size() < 4) q0.push_back(8'($urandom));
      while (q1.size() < 4) q1.push_back(8'($urandom));
      tick();
      fifo_full = ($urandom_range(99, 0) < 25);
      if (n % 700 == 350) begin reset_n = 1'b0; #2; reset_n = 1'b1; end
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
